// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiply/divide issue controller.
//   state_t  : controller FSM states
//   op_t     : latched operation kind
//   md_req_t : operands and destination captured when an instruction is accepted
package multdiv_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;

    localparam int unsigned RSTATUS_REG_DEF   = 30;
    localparam int unsigned MULT_EXC_CODE_DEF = 4;
    localparam int unsigned DIV_EXC_CODE_DEF  = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        TOUT  = 3'd4
    } state_t;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_t;

    typedef struct packed {
        op_t               op;
        logic [DATA_W-1:0] opa;
        logic [DATA_W-1:0] opb;
        logic [REG_W-1:0]  rd;
    } md_req_t;

endpackage

// File: rtl/multdiv_issue_ctrl_wait_counter.sv
// Saturating wait-cycle counter for the issue controller.
//   clock, reset : clock and synchronous active-high reset
//   clear        : load zero
//   en           : count one cycle (saturates at MAX_CYCLES)
//   tc           : this enabled cycle brings the count to MAX_CYCLES
module md_wait_counter #(
    parameter int unsigned MAX_CYCLES = 40,
    localparam int unsigned CNT_W = $clog2(MAX_CYCLES + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] count;

    // Count value k during the (k+1)-th enabled cycle; never wraps.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en && (count != CNT_W'(MAX_CYCLES))) begin
            count <= count + CNT_W'(1);
        end
    end

    // Flag the cycle whose increment reaches the limit, so the limit-th
    // enabled cycle is the last one.
    assign tc = en && (count == CNT_W'(MAX_CYCLES - 1));

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Execute-stage controller feeding the multiply/divide unit: accepts a
// MUL/DIV in execute, issues one start pulse, stalls until the unit answers,
// then emits one writeback beat (result to rd, or exception code to $rstatus).
//   clock, reset             : clock, synchronous active-high reset
//   ex_*                     : instruction in execute (valid, kind, operands, rd)
//   md_ctrl_MULT/DIV         : one-cycle start pulses to the unit
//   md_operandA/B            : operands latched at accept time
//   md_result/exception/RDY  : unit response
//   stall                    : freeze PC/F/D/X registers (combinational)
//   wb_valid/rd/data         : one-cycle writeback beat
//   timeout_err              : sticky, the unit never answered
module multdiv_issue_ctrl
    import multdiv_pkg::*;
#(
    parameter int unsigned MAX_CYCLES    = 40,
    parameter int unsigned RSTATUS_REG   = RSTATUS_REG_DEF,
    parameter int unsigned MULT_EXC_CODE = MULT_EXC_CODE_DEF,
    parameter int unsigned DIV_EXC_CODE  = DIV_EXC_CODE_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic              ex_is_mult,
    input  logic              ex_is_div,
    input  logic [DATA_W-1:0] ex_opA,
    input  logic [DATA_W-1:0] ex_opB,
    input  logic [REG_W-1:0]  ex_rd,
    output logic              md_ctrl_MULT,
    output logic              md_ctrl_DIV,
    output logic [DATA_W-1:0] md_operandA,
    output logic [DATA_W-1:0] md_operandB,
    input  logic [DATA_W-1:0] md_result,
    input  logic              md_exception,
    input  logic              md_resultRDY,
    output logic              stall,
    output logic              wb_valid,
    output logic [REG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              timeout_err
);

    state_t  state;
    md_req_t req_q;
    logic    req;
    logic    cnt_tc;

    assign req = ex_valid && (ex_is_mult || ex_is_div);

    md_wait_counter #(
        .MAX_CYCLES(MAX_CYCLES)
    ) u_wait_counter (
        .clock (clock),
        .reset (reset),
        .clear (state == ISSUE),
        .en    (state == WAIT),
        .tc    (cnt_tc)
    );

    // Controller FSM with registered pulse and writeback outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            req_q        <= '0;
            md_ctrl_MULT <= 1'b0;
            md_ctrl_DIV  <= 1'b0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            timeout_err  <= 1'b0;
        end else begin
            md_ctrl_MULT <= 1'b0;
            md_ctrl_DIV  <= 1'b0;
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            case (state)
                IDLE: begin
                    // Mult wins when both kind bits are set.
                    if (req) begin
                        req_q.op     <= ex_is_mult ? OP_MULT : OP_DIV;
                        req_q.opa    <= ex_opA;
                        req_q.opb    <= ex_opB;
                        req_q.rd     <= ex_rd;
                        md_ctrl_MULT <= ex_is_mult;
                        md_ctrl_DIV  <= !ex_is_mult;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                end
                WAIT: begin
                    // A response in the final allowed cycle still completes.
                    if (md_resultRDY) begin
                        wb_valid <= 1'b1;
                        if (md_exception) begin
                            wb_rd   <= REG_W'(RSTATUS_REG);
                            wb_data <= (req_q.op == OP_MULT) ? DATA_W'(MULT_EXC_CODE)
                                                             : DATA_W'(DIV_EXC_CODE);
                        end else begin
                            wb_rd   <= req_q.rd;
                            wb_data <= md_result;
                        end
                        state <= DONE;
                    end else if (cnt_tc) begin
                        timeout_err <= 1'b1;
                        state       <= TOUT;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                TOUT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign md_operandA = req_q.opa;
    assign md_operandB = req_q.opb;

    // Hold the instruction in execute from acceptance until the writeback cycle.
    always_comb begin
        stall = 1'b0;
        if (!reset) begin
            case (state)
                IDLE:         stall = req;
                ISSUE, WAIT:  stall = 1'b1;
                default:      stall = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
module tb_multdiv_issue_ctrl;

    localparam int unsigned TB_MAX = 40;

    logic        clock = 1'b0;
    logic        reset;
    logic        ex_valid, ex_is_mult, ex_is_div;
    logic [31:0] ex_opA, ex_opB;
    logic [4:0]  ex_rd;
    logic        md_ctrl_MULT, md_ctrl_DIV;
    logic [31:0] md_operandA, md_operandB;
    logic [31:0] md_result;
    logic        md_exception, md_resultRDY;
    logic        stall, wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        timeout_err;

    multdiv_issue_ctrl #(
        .MAX_CYCLES(TB_MAX)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ex_valid     (ex_valid),
        .ex_is_mult   (ex_is_mult),
        .ex_is_div    (ex_is_div),
        .ex_opA       (ex_opA),
        .ex_opB       (ex_opB),
        .ex_rd        (ex_rd),
        .md_ctrl_MULT (md_ctrl_MULT),
        .md_ctrl_DIV  (md_ctrl_DIV),
        .md_operandA  (md_operandA),
        .md_operandB  (md_operandB),
        .md_result    (md_result),
        .md_exception (md_exception),
        .md_resultRDY (md_resultRDY),
        .stall        (stall),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .timeout_err  (timeout_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          is_mult;
        logic [31:0] a;
        logic [31:0] b;
    } pulse_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    pulse_t pulse_q[$];
    wb_t    wb_q[$];
    int     checks = 0;
    int     errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behaviour of the multiply/divide unit the bench plays.
    task automatic unit_model(input bit is_mult, input logic [31:0] a, input logic [31:0] b,
                              output logic [31:0] res, output bit exc);
        longint sa, sb, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (is_mult) begin
            p   = sa * sb;
            res = p[31:0];
            exc = (p < -64'sd2147483648) || (p > 64'sd2147483647);
        end else if (b == 32'd0) begin
            res = 32'd0;
            exc = 1'b1;
        end else begin
            p   = sa / sb;
            res = p[31:0];
            exc = 1'b0;
        end
    endtask

    // Expected writeback beat for a completed operation.
    function automatic wb_t expect_wb(input bit is_mult, input bit exc,
                                      input logic [31:0] res, input logic [4:0] rd);
        wb_t w;
        if (exc) begin
            w.rd   = 5'd30;
            w.data = is_mult ? 32'd4 : 32'd5;
        end else begin
            w.rd   = rd;
            w.data = res;
        end
        return w;
    endfunction

    // Monitor: every start pulse and writeback beat must match the next expectation.
    always @(negedge clock) begin
        if (reset === 1'b0) begin
            if (md_ctrl_MULT || md_ctrl_DIV) begin
                if (pulse_q.size() == 0) begin
                    chk("pulse_unexpected", 32'({md_ctrl_MULT, md_ctrl_DIV}), 32'd0);
                end else begin
                    pulse_t p;
                    p = pulse_q.pop_front();
                    chk("pulse_mult", 32'(md_ctrl_MULT), 32'(p.is_mult));
                    chk("pulse_div", 32'(md_ctrl_DIV), 32'(!p.is_mult));
                    chk("operand_a", md_operandA, p.a);
                    chk("operand_b", md_operandB, p.b);
                end
            end
            if (wb_valid) begin
                if (wb_q.size() == 0) begin
                    chk("wb_unexpected", 32'(wb_valid), 32'd0);
                end else begin
                    wb_t w;
                    w = wb_q.pop_front();
                    chk("wb_rd", 32'(wb_rd), 32'(w.rd));
                    chk("wb_data", wb_data, w.data);
                end
            end
        end
    end

    // One instruction, starting at a negedge in an IDLE cycle and ending at
    // the negedge of the following IDLE cycle. delay = cycles from pulse to
    // RDY; delay > TB_MAX means the unit never answers.
    task automatic run_op(input bit is_mult, input bit is_div, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input int delay, input bit stale);
        bit          eff_mult;
        bit          exc;
        bit          tout;
        logic [31:0] res;
        int          end_cyc;
        eff_mult = is_mult;
        unit_model(eff_mult, a, b, res, exc);
        tout    = (delay > int'(TB_MAX));
        end_cyc = tout ? 2 + int'(TB_MAX) : 2 + delay;
        pulse_q.push_back('{eff_mult, a, b});
        if (!tout) wb_q.push_back(expect_wb(eff_mult, exc, res, rd));

        ex_valid   = 1'b1;
        ex_is_mult = is_mult;
        ex_is_div  = is_div;
        ex_opA     = a;
        ex_opB     = b;
        ex_rd      = rd;
        md_resultRDY = 1'b0;
        #1 chk("stall_accept", 32'(stall), 32'd1);
        for (int c = 1; c <= end_cyc; c++) begin
            @(negedge clock);
            ex_opA     = $urandom;
            ex_opB     = $urandom;
            ex_rd      = 5'($urandom);
            ex_is_mult = 1'($urandom);
            ex_is_div  = 1'($urandom);
            ex_valid   = (c < end_cyc);
            if (!tout && c == 1 + delay) begin
                md_resultRDY = 1'b1;
                md_result    = res;
                md_exception = exc;
            end else begin
                md_resultRDY = stale && (c == 1);
                md_result    = $urandom;
                md_exception = 1'($urandom);
            end
            #1 chk("stall", 32'(stall), 32'(c < end_cyc));
            if (tout && c == end_cyc) chk("timeout_err_set", 32'(timeout_err), 32'd1);
        end
        @(negedge clock);
        md_resultRDY = 1'b0;
    endtask

    // Cycles with no multiply/divide in execute: no stall, no issue.
    task automatic idle(input int n);
        repeat (n) begin
            ex_valid     = 1'($urandom);
            ex_is_mult   = 1'b0;
            ex_is_div    = 1'b0;
            ex_opA       = $urandom;
            ex_opB       = $urandom;
            md_resultRDY = 1'($urandom);
            #1 chk("stall_idle", 32'(stall), 32'd0);
            @(negedge clock);
        end
        md_resultRDY = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall), 32'd0);
        chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
        chk({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
        chk({tag, "_wb_data"}, wb_data, 32'd0);
        chk({tag, "_ctrl"}, 32'({md_ctrl_MULT, md_ctrl_DIV}), 32'd0);
        chk({tag, "_opA"}, md_operandA, 32'd0);
        chk({tag, "_opB"}, md_operandB, 32'd0);
        chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    endtask

    // Reset asserted in WAIT: no writeback, late RDY afterwards is ignored.
    task automatic reset_mid_wait(input logic [31:0] a, input logic [31:0] b);
        pulse_q.push_back('{1'b1, a, b});
        ex_valid   = 1'b1;
        ex_is_mult = 1'b1;
        ex_is_div  = 1'b0;
        ex_opA     = a;
        ex_opB     = b;
        ex_rd      = 5'd7;
        repeat (5) @(negedge clock);
        ex_valid = 1'b0;
        reset    = 1'b1;
        #1 chk("reset_stall_now", 32'(stall), 32'd0);
        @(negedge clock);
        check_all_zero("reset_mid");
        reset        = 1'b0;
        md_resultRDY = 1'b1;
        md_result    = 32'h1234_5678;
        md_exception = 1'b0;
        #1 chk("late_rdy_stall", 32'(stall), 32'd0);
        @(negedge clock);
        md_resultRDY = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    initial begin
        reset        = 1'b1;
        ex_valid     = 1'b0;
        ex_is_mult   = 1'b0;
        ex_is_div    = 1'b0;
        ex_opA       = '0;
        ex_opB       = '0;
        ex_rd        = '0;
        md_result    = '0;
        md_exception = 1'b0;
        md_resultRDY = 1'b0;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;
        idle(2);

        run_op(1, 0, 32'd7, 32'hFFFF_FFFD, 5'd5, 17, 0);       // 7 x -3
        run_op(0, 1, 32'd100, 32'd0, 5'd9, 4, 0);              // divide by zero
        run_op(1, 0, 32'h7FFF_FFFF, 32'd2, 5'd3, 2, 0);        // multiply overflow
        run_op(1, 0, 32'd12, 32'd11, 5'd1, 1, 0);              // back-to-back MUL
        run_op(0, 1, 32'd1000, 32'hFFFF_FFF9, 5'd2, 3, 0);     // then DIV
        run_op(0, 1, 32'd77, 32'd7, 5'd4, 6, 1);               // stale RDY in ISSUE
        run_op(1, 1, 32'd6, 32'd9, 5'd0, int'(TB_MAX), 0);     // both set, rd=0, last cycle
        idle(3);
        chk("timeout_err_clear", 32'(timeout_err), 32'd0);
        run_op(0, 1, 32'd5, 32'd1, 5'd8, int'(TB_MAX) + 1, 0); // unit never answers
        run_op(1, 0, 32'd3, 32'd3, 5'd10, 2, 0);
        chk("timeout_err_sticky", 32'(timeout_err), 32'd1);
        reset_mid_wait(32'd21, 32'd2);
        chk("timeout_err_after_reset", 32'(timeout_err), 32'd0);

        for (int i = 0; i < 25; i++) begin
            bit          m, d;
            logic [31:0] a, b;
            m = 1'($urandom);
            d = m ? 1'($urandom) : 1'b1;
            a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($signed(16'($urandom)));
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($signed(12'($urandom)));
            run_op(m, d, a, b, 5'($urandom), int'($urandom_range(1, 12)), 1'($urandom));
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
        end

        repeat (3) @(negedge clock);
        chk("pulse_queue_empty", 32'(pulse_q.size()), 32'd0);
        chk("wb_queue_empty", 32'(wb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
